// File: rtl/otter_bpu_if.sv
// otter_bpu bus bundle: fetch lookup, execute resolve, flush and stats.
// master = pipeline side, slave = branch prediction unit side.
interface otter_bpu_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      IF_PC;
  logic             PRED_TAKEN;
  logic [31:0]      PRED_TARGET;
  logic             EX_VALID;
  logic             EX_IS_BR;
  logic [31:0]      EX_PC;
  logic             EX_TAKEN;
  logic [31:0]      EX_TARGET;
  logic             EX_PRED_TAKEN;
  logic [31:0]      EX_PRED_TARGET;
  logic             MISPREDICT;
  logic             FLUSH;
  logic [31:0]      REDIRECT_PC;
  logic [CNT_W-1:0] BR_COUNT;
  logic [CNT_W-1:0] MISS_COUNT;

  modport master (
    output IF_PC, EX_VALID, EX_IS_BR, EX_PC, EX_TAKEN,
    output EX_TARGET, EX_PRED_TAKEN, EX_PRED_TARGET,
    input  PRED_TAKEN, PRED_TARGET, MISPREDICT, FLUSH,
    input  REDIRECT_PC, BR_COUNT, MISS_COUNT
  );

  modport slave (
    input  IF_PC, EX_VALID, EX_IS_BR, EX_PC, EX_TAKEN,
    input  EX_TARGET, EX_PRED_TAKEN, EX_PRED_TARGET,
    output PRED_TAKEN, PRED_TARGET, MISPREDICT, FLUSH,
    output REDIRECT_PC, BR_COUNT, MISS_COUNT
  );
endinterface

// File: rtl/otter_bpu.sv
// otter_bpu: direct-mapped BTB + 2-bit counters, same-cycle predict,
// EX-stage train/mispredict/redirect, saturating stats. Ports: CLK, RESET, bus.
module otter_bpu #(
  parameter int         ENTRIES  = 64,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int         CNT_W    = 32
) (
  input logic        CLK,
  input logic        RESET,
  otter_bpu_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic        valid_q [ENTRIES];
  logic        valid_d [ENTRIES];
  tag_t        tag_q   [ENTRIES];
  tag_t        tag_d   [ENTRIES];
  logic [31:0] tgt_q   [ENTRIES];
  logic [31:0] tgt_d   [ENTRIES];
  logic [1:0]  ctr_q   [ENTRIES];
  logic [1:0]  ctr_d   [ENTRIES];

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  idx_t if_idx, ex_idx;
  tag_t if_tag, ex_tag;
  logic if_hit, ex_hit;
  logic pred_taken;
  logic mispredict;
  logic train;
  logic alias_inv;
  logic unused_pc;

  assign unused_pc = ^{bus.IF_PC, bus.EX_PC};

  always_comb begin
    if_idx = bus.IF_PC[IDX_W+1:2];
    if_tag = bus.IF_PC[IDX_W+TAG_W+1:IDX_W+2];
    ex_idx = bus.EX_PC[IDX_W+1:2];
    ex_tag = bus.EX_PC[IDX_W+TAG_W+1:IDX_W+2];
    if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    pred_taken = if_hit && ctr_q[if_idx][1];
  end

  assign bus.PRED_TAKEN  = pred_taken;
  assign bus.PRED_TARGET = pred_taken ? tgt_q[if_idx]
                                      : bus.IF_PC + 32'd4;

  // A non-branch that was predicted taken hit a stale aliased entry.
  always_comb begin
    mispredict = 1'b0;
    if (bus.EX_VALID) begin
      if (bus.EX_IS_BR) begin
        mispredict = (bus.EX_TAKEN != bus.EX_PRED_TAKEN) ||
                     (bus.EX_TAKEN &&
                      (bus.EX_TARGET != bus.EX_PRED_TARGET));
      end else begin
        mispredict = bus.EX_PRED_TAKEN;
      end
    end
  end

  assign bus.MISPREDICT  = mispredict;
  assign bus.FLUSH       = mispredict;
  assign bus.REDIRECT_PC = (bus.EX_IS_BR && bus.EX_TAKEN)
                           ? bus.EX_TARGET
                           : bus.EX_PC + 32'd4;

  assign train     = bus.EX_VALID && bus.EX_IS_BR;
  assign alias_inv = bus.EX_VALID && !bus.EX_IS_BR &&
                     bus.EX_PRED_TAKEN;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (train) begin
      if (ex_hit) begin
        if (bus.EX_TAKEN) begin
          if (ctr_q[ex_idx] != 2'd3)
            ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
          tgt_d[ex_idx] = bus.EX_TARGET;
        end else if (ctr_q[ex_idx] != 2'd0) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
      end else if (bus.EX_TAKEN) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = bus.EX_TARGET;
        ctr_d[ex_idx]   = 2'b10;
      end
    end else if (alias_inv) begin
      valid_d[ex_idx] = 1'b0;
    end
  end

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (train && !(&br_cnt_q))
      br_cnt_d = br_cnt_q + CNT_W'(1);
    if (mispredict && !(&miss_cnt_q))
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
  end

  assign bus.BR_COUNT   = br_cnt_q;
  assign bus.MISS_COUNT = miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      ctr_q      <= ctr_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tags/targets need no reset; holding them during reset keeps a
  // discarded update from leaving partial contents behind.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
    end
  end
endmodule

// File: tb/tb_otter_bpu.sv
// Bench for otter_bpu: directed test plan plus random traffic against a
// behavioural BTB model; second instance with CNT_W=4 for saturation.
module tb_otter_bpu;
  logic CLK;
  logic RESET;

  otter_bpu_if #(.CNT_W(32)) bus ();
  otter_bpu_if #(.CNT_W(4))  bus2 ();

  otter_bpu #(.CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );
  otter_bpu #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .bus(bus2.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  bit          mv   [64];
  int          mtag [64];
  logic [31:0] mtgt [64];
  int          mctr [64];
  longint      mbr, mmiss;

  logic        o_pt, o_mp;
  logic [31:0] o_ptg, o_rd, o_br, o_miss;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3f);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 8) & 32'hff);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mv[i]   = 1'b0;
      mctr[i] = 1;
    end
    mbr   = 0;
    mmiss = 0;
  endtask

  task automatic mpred(input logic [31:0] pc,
                       output logic t, output logic [31:0] g);
    int i;
    i = idx_of(pc);
    t = mv[i] && (mtag[i] == tag_of(pc)) && (mctr[i] >= 2);
    g = t ? mtgt[i] : pc + 32'd4;
  endtask

  task automatic step(input logic rst, input logic [31:0] ifpc,
                      input logic v, input logic isbr,
                      input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ptgt);
    logic        et, emp;
    logic [31:0] eg, erd;
    int          i, tg;
    RESET              = rst;
    bus.IF_PC          = ifpc;
    bus.EX_VALID       = v;
    bus.EX_IS_BR       = isbr;
    bus.EX_PC          = pc;
    bus.EX_TAKEN       = tk;
    bus.EX_TARGET      = tgt;
    bus.EX_PRED_TAKEN  = ptk;
    bus.EX_PRED_TARGET = ptgt;
    #1;
    mpred(ifpc, et, eg);
    emp = v && (isbr ? ((tk != ptk) || (tk && (tgt != ptgt))) : ptk);
    erd = (isbr && tk) ? tgt : pc + 32'd4;
    o_pt   = bus.PRED_TAKEN;
    o_ptg  = bus.PRED_TARGET;
    o_mp   = bus.MISPREDICT;
    o_rd   = bus.REDIRECT_PC;
    o_br   = bus.BR_COUNT;
    o_miss = bus.MISS_COUNT;
    chk("pred_taken", {31'b0, o_pt}, {31'b0, et});
    chk("pred_target", o_ptg, eg);
    chk("mispredict", {31'b0, o_mp}, {31'b0, emp});
    chk("flush", {31'b0, bus.FLUSH}, {31'b0, emp});
    if (emp) chk("redirect", o_rd, erd);
    chk("br_count", o_br, mbr[31:0]);
    chk("miss_count", o_miss, mmiss[31:0]);
    @(posedge CLK);
    i  = idx_of(pc);
    tg = tag_of(pc);
    if (rst) begin
      model_reset();
    end else begin
      if (emp) mmiss++;
      if (v && isbr) begin
        mbr++;
        if (mv[i] && mtag[i] == tg) begin
          if (tk) begin
            mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
            mtgt[i] = tgt;
          end else begin
            mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
          end
        end else if (tk) begin
          mv[i]   = 1'b1;
          mtag[i] = tg;
          mtgt[i] = tgt;
          mctr[i] = 2;
        end
      end else if (v && ptk) begin
        mv[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic ex(input logic [31:0] ifpc, input logic isbr,
                    input logic [31:0] pc, input logic tk,
                    input logic [31:0] tgt);
    logic        pt;
    logic [31:0] pg;
    mpred(pc, pt, pg);
    step(1'b0, ifpc, 1'b1, isbr, pc, tk, tgt, pt, pg);
  endtask

  task automatic idle(input logic [31:0] ifpc);
    step(1'b0, ifpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] pc, ifpc, tgt, ptgt;
    logic        v, isbr, tk, ptk;
    RESET = 1'b1;
    bus.IF_PC = 0; bus.EX_VALID = 0; bus.EX_IS_BR = 0;
    bus.EX_PC = 0; bus.EX_TAKEN = 0; bus.EX_TARGET = 0;
    bus.EX_PRED_TAKEN = 0; bus.EX_PRED_TARGET = 0;
    bus2.IF_PC = 0; bus2.EX_VALID = 0; bus2.EX_IS_BR = 0;
    bus2.EX_PC = 0; bus2.EX_TAKEN = 0; bus2.EX_TARGET = 0;
    bus2.EX_PRED_TAKEN = 0; bus2.EX_PRED_TARGET = 0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();

    idle(32'h100);
    chk("cold_pt", {31'b0, o_pt}, 32'h0);
    chk("cold_tgt", o_ptg, 32'h104);
    chk("cold_br", o_br, 32'h0);

    ex(32'h100, 1'b1, 32'h100, 1'b1, 32'h80);
    chk("alloc_mp", {31'b0, o_mp}, 32'h1);
    chk("alloc_rd", o_rd, 32'h80);
    idle(32'h100);
    chk("hit_pt", {31'b0, o_pt}, 32'h1);
    chk("hit_tgt", o_ptg, 32'h80);
    chk("hit_miss", o_miss, 32'h1);

    ex(32'h0, 1'b1, 32'h100, 1'b0, 32'h80);
    ex(32'h0, 1'b1, 32'h100, 1'b0, 32'h80);
    idle(32'h100);
    chk("hyst_nt", {31'b0, o_pt}, 32'h0);
    repeat (3) ex(32'h0, 1'b1, 32'h100, 1'b1, 32'h80);
    ex(32'h0, 1'b1, 32'h100, 1'b0, 32'h80);
    idle(32'h100);
    chk("hyst_sat", {31'b0, o_pt}, 32'h1);

    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0,
         1'b1, 32'h80);
    chk("alias_mp", {31'b0, o_mp}, 32'h1);
    chk("alias_rd", o_rd, 32'h204);
    idle(32'h100);
    chk("alias_inv", {31'b0, o_pt}, 32'h0);

    ex(32'h0, 1'b1, 32'h40, 1'b1, 32'h90);
    ex(32'h40, 1'b1, 32'h40, 1'b1, 32'hA0);
    chk("tchg_mp", {31'b0, o_mp}, 32'h1);
    chk("tchg_rd", o_rd, 32'hA0);
    idle(32'h40);
    chk("tchg_tgt", o_ptg, 32'hA0);

    for (int n = 0; n < 300; n++) begin
      pc   = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      ifpc = ($urandom_range(0, 3) == 0) ? pc :
             (($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2));
      v    = ($urandom_range(0, 9) != 0);
      isbr = ($urandom_range(0, 9) < 7);
      tk   = 1'($urandom_range(0, 1));
      tgt  = 32'h1000 + ($urandom_range(0, 3) << 4);
      mpred(pc, ptk, ptgt);
      if ($urandom_range(0, 3) == 0) begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = 32'h1000 + ($urandom_range(0, 3) << 4);
      end
      step(1'b0, ifpc, v, isbr, pc, tk, tgt, ptk, ptgt);
    end

    step(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,
         1'b0, 32'h104);
    idle(32'h100);
    chk("rst_pt", {31'b0, o_pt}, 32'h0);
    chk("rst_br", o_br, 32'h0);
    chk("rst_miss", o_miss, 32'h0);

    bus2.EX_VALID      = 1'b1;
    bus2.EX_PC         = 32'h300;
    bus2.EX_PRED_TAKEN = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("sat_mid", {28'b0, bus2.MISS_COUNT}, 32'd10);
    repeat (10) @(posedge CLK);
    #1;
    chk("sat_miss", {28'b0, bus2.MISS_COUNT}, 32'd15);
    chk("sat_br", {28'b0, bus2.BR_COUNT}, 32'd0);
    chk("sat_mp", {31'b0, bus2.MISPREDICT}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/otter_bpu.md
# otter_bpu

Parametrised branch prediction unit for the pipelined OTTER. It sits beside the fetch-stage PC register and performs a same-cycle lookup of the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, producing a predicted next PC. Resolved control-flow outcomes are fed back from the execute stage; the unit trains its tables, detects mispredictions and issues a flush and redirect PC for the IF/DE and DE/EX pipeline registers. It also keeps saturating branch and mispredict statistics counters.

## Interface
- ENTRIES, 64, number of BTB entries; power of two, at least 2; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag width; IDX_W + TAG_W + 2 must be at most 32
- CTR_INIT, 2'b01, counter value loaded on reset (weakly not-taken)
- CNT_W, 32, width of the statistics counters
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- IF_PC  in  32  current fetch PC (byte address)
- PRED_TAKEN  out  1  prediction for IF_PC; combinational
- PRED_TARGET  out  32  predicted next PC; combinational
- EX_VALID  in  1  execute stage holds a real instruction (not a bubble)
- EX_IS_BR  in  1  instruction in execute is BRANCH, JAL or JALR
- EX_PC  in  32  PC of the instruction in execute
- EX_TAKEN  in  1  resolved outcome (JAL/JALR are always 1)
- EX_TARGET  in  32  resolved target (branch_pc, jump_pc or jalr_pc)
- EX_PRED_TAKEN  in  1  PRED_TAKEN value piped with this instruction
- EX_PRED_TARGET  in  32  PRED_TARGET value piped with this instruction
- MISPREDICT  out  1  combinational mispredict flag
- FLUSH  out  1  equal to MISPREDICT; squashes IF/DE and DE/EX
- REDIRECT_PC  out  32  correct next PC, valid while MISPREDICT is 1
- BR_COUNT  out  CNT_W  resolved control-flow instructions, saturating
- MISS_COUNT  out  CNT_W  mispredicts, saturating

## Operation
- Index = PC[IDX_W+1:2]. Tag = PC[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds a valid bit, a tag, a 32-bit target and a 2-bit counter.
- Lookup: hit = valid[idx] && (tag[idx] == IF_PC tag).
  - PRED_TAKEN = hit && ctr[idx][1].
  - PRED_TARGET = PRED_TAKEN ? target[idx] : IF_PC + 4, computed modulo 2^32.
- Mispredict, when EX_VALID is 1:
  - If EX_IS_BR: mispredict when EX_TAKEN != EX_PRED_TAKEN, or when EX_TAKEN is 1 and EX_TARGET != EX_PRED_TARGET.
  - If not EX_IS_BR: mispredict when EX_PRED_TAKEN is 1 (stale alias).
  - When EX_VALID is 0: MISPREDICT = 0.
- REDIRECT_PC = (EX_IS_BR && EX_TAKEN) ? EX_TARGET : EX_PC + 4.
- Training, on each edge where EX_VALID && EX_IS_BR, for the entry at EX_PC's index:
  - Tag hit: the counter increments if taken and decrements if not taken, saturating at 3 and 0. If taken, target is set to EX_TARGET.
  - Tag miss, taken: allocate (valid=1, tag, target=EX_TARGET, ctr=2'b10), replacing any occupant.
  - Tag miss, not taken: no change.
- Alias invalidation: on an edge where EX_VALID && !EX_IS_BR && EX_PRED_TAKEN, the entry at EX_PC's index is invalidated.
- Statistics:
  - BR_COUNT increments on every training edge (EX_VALID && EX_IS_BR).
  - MISS_COUNT increments on every edge where MISPREDICT is 1.
  - Both hold at all-ones once reached.

## Timing
- Lookup has zero latency: PRED_* depend only on IF_PC and the current table state.
- MISPREDICT, FLUSH and REDIRECT_PC have zero latency from the EX_* inputs. The PC mux loads REDIRECT_PC on the same edge.
- Table writes become visible at the next cycle. A lookup and an update to the same index in the same cycle returns the pre-update contents.
- RESET takes priority over training and counting. On the reset edge:
  - valid is cleared and every counter is set to CTR_INIT.
  - Targets and tags are don't-care.
  - BR_COUNT and MISS_COUNT are set to 0.
- Outputs in the cycle after reset:
  - PRED_TAKEN = 0 and PRED_TARGET = IF_PC + 4.
  - MISPREDICT and FLUSH follow the EX_* inputs only.
- A reset asserted mid-stream discards the in-flight update; no partial entry is written.
- Reset does not gate the combinational outputs. The surrounding pipeline holds EX_VALID low during reset.

## Test plan
- Cold predict: after reset, IF_PC=0x0000_0100 -> PRED_TAKEN=0, PRED_TARGET=0x0000_0104, BR_COUNT=0.
- Allocate and hit: retire a taken branch with EX_PC=0x100, EX_TARGET=0x80 and EX_PRED_TAKEN=0 -> MISPREDICT=1, REDIRECT_PC=0x80, MISS_COUNT=1. Next cycle IF_PC=0x100 -> PRED_TAKEN=1, PRED_TARGET=0x80.
- Counter hysteresis: after the allocation, retire two not-taken at 0x100 -> the prediction becomes not-taken (counter 0). Three taken -> counter saturates at 3; one not-taken -> still predicted taken.
- Aliasing: with ENTRIES=64, TAG_W=8, allocate at 0x100, then retire EX_PC=0x200 (same index, different tag) as not-branch with EX_PRED_TAKEN=1 -> MISPREDICT=1, REDIRECT_PC=0x204, entry invalidated. A lookup of 0x100 then misses.
- Target change: JALR at 0x40, predicted taken to 0x90, resolves taken to 0xA0 -> MISPREDICT=1, REDIRECT_PC=0xA0. The next lookup of 0x40 predicts 0xA0.
- Reset mid-update: assert RESET on the same edge as a taken allocation at 0x100 -> the next lookup misses, BR_COUNT=0, MISS_COUNT=0. Run CNT_W=4 with 20 mispredicts -> MISS_COUNT=15.
